// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory model behind the unified I/D cache.
//   BLOCK_W / WORD_W : block and word widths (a block holds eight words,
//                      word 0 in the most significant 32 bits)
//   block_t          : one 256-bit memory block
//   mem_state_e      : controller states (CLEAR only reachable with
//                      MEM_BLOCK_CLEAR_EN defined)
package mem_pkg;

    localparam int unsigned BLOCK_W = 256;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_W / WORD_W;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_e;

    // Word w of a block; word 0 lives in the top bits.
    function automatic logic [WORD_W-1:0] block_word(input block_t blk, input int unsigned w);
        return blk[BLOCK_W - 1 - w * WORD_W -: WORD_W];
    endfunction

endpackage

// File: rtl/mem_block_ram.sv
// block_ram: DEPTH x 256-bit storage with one write port and two registered
// read ports. Reads are read-first: a read and a write to the same index on
// the same edge return the old contents.
//   clk, reset      : clock; synchronous active-high reset clears the read
//                     registers only (array contents are not reset)
//   we/waddr/wdata  : write port
//   re              : read strobe shared by both read ports
//   raddr_a/rdata_a : read port A (instruction side)
//   raddr_b/rdata_b : read port B (data side)
module block_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  block_t        wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output block_t        rdata_a,
    output block_t        rdata_b
);

    block_t mem_q [DEPTH];
    block_t rdata_a_q;
    block_t rdata_b_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem_q above makes these reads see pre-write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (re) begin
            rdata_a_q <= mem_q[raddr_a];
            rdata_b_q <= mem_q[raddr_b];
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/mem_block.sv
// mem_block: main-memory model serving whole 256-bit block transfers to the
// unified cache. Two read ports (instruction, data) share blockread; one
// write port. Read latency is one cycle; addresses alias modulo DEPTH.
//   clk, reset          : clock; synchronous active-high reset
//   blockwrite          : store writeblock at writeaddr
//   blockread           : load instrblock/readblock from instraddr/readaddr
//   instraddr/readaddr  : block addresses for the read ports
//   writeaddr           : block address for the write port
//   writeblock          : data to write
//   readblock/instrblock: registered read data
//   memready            : requests accepted while high
// Optional feature: define MEM_BLOCK_CLEAR_EN to zero the whole array after
// every reset (memready stays low for DEPTH cycles while sweeping).
module mem_block
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        blockwrite,
    input  logic        blockread,
    input  logic [31:0] instraddr,
    input  logic [31:0] readaddr,
    input  logic [31:0] writeaddr,
    input  block_t      writeblock,
    output block_t      readblock,
    output block_t      instrblock,
    output logic        memready
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef MEM_BLOCK_CLEAR_EN
    localparam mem_state_e RstState = CLEAR;
`else
    localparam mem_state_e RstState = IDLE;
`endif

    mem_state_e state_q, state_d;
    logic       ready_q;
    logic       accept;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    block_t        ram_wdata;
    logic          ram_re;

`ifdef MEM_BLOCK_CLEAR_EN
    logic [AW-1:0] sweep_q, sweep_d;
`endif

    // Upper address bits are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instraddr[31:AW], readaddr[31:AW], writeaddr[31:AW]};

    // Strobes coinciding with reset are dropped even if ready_q is still high.
    assign accept   = ready_q && !reset;
    assign memready = ready_q;

    always_comb begin
        state_d = state_q;
`ifdef MEM_BLOCK_CLEAR_EN
        sweep_d = sweep_q;
        unique case (state_q)
            CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: state_d = IDLE;
            default: state_d = RstState;
        endcase
`else
        state_d = IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RstState;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered so memready rises on the same edge the sweep finishes.
            ready_q <= (state_d == IDLE);
        end
    end

`ifdef MEM_BLOCK_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_q <= '0;
        end else begin
            sweep_q <= sweep_d;
        end
    end
`endif

    // Write port mux: sweep writes zeros while clearing, otherwise the cache.
    always_comb begin
        ram_we    = accept && blockwrite;
        ram_waddr = writeaddr[AW-1:0];
        ram_wdata = writeblock;
`ifdef MEM_BLOCK_CLEAR_EN
        if (state_q == CLEAR && !reset) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_q;
            ram_wdata = '0;
        end
`endif
    end

    assign ram_re = accept && blockread;

    block_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_block_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .raddr_a (instraddr[AW-1:0]),
        .raddr_b (readaddr[AW-1:0]),
        .rdata_a (instrblock),
        .rdata_b (readblock)
    );

endmodule

// File: tb/tb_mem_block.sv
// Bench for mem_block: directed steps from the test plan followed by random
// traffic, compared against an array-based reference of the memory.
module tb_mem_block;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 16;

`ifdef MEM_BLOCK_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        blockwrite, blockread;
    logic [31:0] instraddr, readaddr, writeaddr;
    block_t      writeblock;
    block_t      readblock, instrblock;
    logic        memready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    block_t ref_mem [DEPTH];
    bit     ref_ok  [DEPTH];
    block_t exp_rd, exp_ir;
    bit     exp_rd_ok, exp_ir_ok;
    bit     exp_ready = 1'b0;
    int     clear_left = 0;

    mem_block #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .blockwrite (blockwrite),
        .blockread  (blockread),
        .instraddr  (instraddr),
        .readaddr   (readaddr),
        .writeaddr  (writeaddr),
        .writeblock (writeblock),
        .readblock  (readblock),
        .instrblock (instrblock),
        .memready   (memready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input block_t obs, input block_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the model, advance, then compare.
    task automatic do_cycle();
        block_t nrd = exp_rd;
        block_t nir = exp_ir;
        bit     nrd_ok = exp_rd_ok;
        bit     nir_ok = exp_ir_ok;
        if (reset) begin
            nrd = '0; nir = '0; nrd_ok = 1'b1; nir_ok = 1'b1;
        end else if (exp_ready) begin
            if (blockread) begin
                nrd    = ref_mem[readaddr % DEPTH];
                nrd_ok = ref_ok[readaddr % DEPTH];
                nir    = ref_mem[instraddr % DEPTH];
                nir_ok = ref_ok[instraddr % DEPTH];
            end
            if (blockwrite) begin
                ref_mem[writeaddr % DEPTH] = writeblock;
                ref_ok[writeaddr % DEPTH]  = 1'b1;
            end
        end
        if (reset) begin
            exp_ready  = 1'b0;
            clear_left = CLEAR_EN ? DEPTH : 0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ref_mem[i] = '0;
                    ref_ok[i]  = 1'b1;
                end
                exp_ready = 1'b1;
            end
        end else begin
            exp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_rd = nrd; exp_ir = nir; exp_rd_ok = nrd_ok; exp_ir_ok = nir_ok;
        chk("memready", block_t'(memready), block_t'(exp_ready));
        if (exp_rd_ok) chk("model_readblock", readblock, exp_rd);
        if (exp_ir_ok) chk("model_instrblock", instrblock, exp_ir);
    endtask

    task automatic wr(input logic [31:0] a, input block_t d);
        blockwrite = 1'b1; writeaddr = a; writeblock = d;
        do_cycle();
        blockwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] ia, input logic [31:0] ra);
        blockread = 1'b1; instraddr = ia; readaddr = ra;
        do_cycle();
        blockread = 1'b0;
    endtask

    // Release reset and count cycles until memready rises (bounded).
    task automatic release_and_wait(input string tag);
        int n = 0;
        reset = 1'b0;
        do_cycle();
        while (!memready && n < DEPTH + 8) begin
            n++;
            do_cycle();
        end
        chk(tag, block_t'(n), block_t'(CLEAR_EN ? DEPTH - 1 : 0));
    endtask

    initial begin
        block_t ka, kb, kc, kd, ke, kk;
        ka = {8{32'hAAAA_0001}};
        kb = {8{32'hBBBB_0002}};
        kc = {8{32'hCCCC_0003}};
        kd = {8{32'hDDDD_0004}};
        ke = {8{32'hEEEE_0005}};
        kk = 256'h01234567_89ABCDEF_FEDCBA98_76543210_00112233_44556677_8899AABB_CCDDABCD;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_ok[i]  = 1'b0;
        end
        exp_rd_ok = 1'b0; exp_ir_ok = 1'b0;
        exp_rd = '0; exp_ir = '0;
        reset = 1'b1; blockwrite = 1'b0; blockread = 1'b0;
        instraddr = '0; readaddr = '0; writeaddr = '0; writeblock = '0;

        // Reset held two cycles, with a strobe that must be dropped.
        do_cycle();
        blockwrite = 1'b1; writeaddr = 32'd1; writeblock = ka;
        do_cycle();
        blockwrite = 1'b0;
        chk("reset_readblock", readblock, '0);
        chk("reset_instrblock", instrblock, '0);
        chk("reset_memready", block_t'(memready), '0);
        release_and_wait("ready_latency");

        if (CLEAR_EN) begin
            rd(32'd5, 32'd5);
            chk("cleared_idx5", readblock, '0);
        end

        // Write/read back
        wr(32'd7, kk);
        rd(32'd0, 32'd7);
        chk("readback_7", readblock, kk);

        // Dual read
        wr(32'd3, ka);
        wr(32'd9, kb);
        rd(32'd3, 32'd9);
        chk("dual_instr", instrblock, ka);
        chk("dual_data", readblock, kb);

        // Collision: read-first, then new data visible next cycle
        wr(32'd4, kd);
        blockread = 1'b1; readaddr = 32'd4; instraddr = 32'd3;
        blockwrite = 1'b1; writeaddr = 32'd4; writeblock = kc;
        do_cycle();
        blockwrite = 1'b0;
        chk("collision_old", readblock, kd);
        do_cycle();
        blockread = 1'b0;
        chk("collision_new", readblock, kc);

        // Aliasing and hold
        wr(DEPTH + 2, ke);
        rd(32'd3, 32'd2);
        chk("alias_read", readblock, ke);
        readaddr = 32'd7; instraddr = 32'd9;
        do_cycle();
        do_cycle();
        chk("hold_data", readblock, ke);
        chk("hold_instr", instrblock, ka);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            blockread  = ($urandom_range(0, 1) == 1);
            blockwrite = ($urandom_range(0, 2) != 0);
            instraddr  = ($urandom_range(0, 7) == 0) ? $urandom()
                         : $urandom_range(0, 3) * DEPTH + $urandom_range(0, DEPTH - 1);
            readaddr   = ($urandom_range(0, 7) == 0) ? $urandom()
                         : $urandom_range(0, 3) * DEPTH + $urandom_range(0, DEPTH - 1);
            writeaddr  = ($urandom_range(0, 3) == 0) ? readaddr
                         : $urandom_range(0, 3) * DEPTH + $urandom_range(0, DEPTH - 1);
            writeblock = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
            reset      = ($urandom_range(0, 127) == 0);
            do_cycle();
        end
        reset = 1'b0; blockread = 1'b0; blockwrite = 1'b0;
        while (clear_left > 0) do_cycle();
        do_cycle();

        // Mid-operation reset during a read burst
        wr(32'd7, kk);
        blockread = 1'b1; readaddr = 32'd7; instraddr = 32'd7;
        do_cycle();
        do_cycle();
        chk("burst_data", readblock, kk);
        reset = 1'b1;
        do_cycle();
        chk("midreset_readblock", readblock, '0);
        chk("midreset_instrblock", instrblock, '0);
        chk("midreset_memready", block_t'(memready), '0);
        blockread = 1'b0;
        release_and_wait("ready_latency_again");
        rd(32'd7, 32'd7);
        chk("after_reset_idx7", readblock, CLEAR_EN ? block_t'('0) : kk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
